instr_dispatch_queue: RTL and testbench
=======================================

// Module: instr_dispatch_queue
// PURPOSE
// - Pop end of the control-unit instruction queue. Buffers in-order entries pushed by control_unit (queue_we + payload) and
//   dispatches the head entry, one per cycle, to the load/store, RAM or arithmetic issue port selected by its type.
// - Back-pressures the control unit with queue_full; flags protocol violations on a sticky queue_error.
// PARAMETERS
// - LOG_DEPTH  4  log2 of entry count; DEPTH = 1<<LOG_DEPTH entries of 93 bits each.
// PORTS
// - clk                input   1   clock, all state updates on posedge
// - reset_n            input   1   asynchronous, active-low reset
// - flush              input   1   synchronous clear of all entries (program abort)
// - queue_we           input   1   push strobe from control unit
// - queue_instr_type   input   2   0=LD_ST 1=RAM 2=ARITH 3=LOOP(illegal here)
// - queue_arith_instr  input   9   arithmetic payload
// - queue_ram_instr    input   3   {is_write, cache_slot}
// - queue_ld_st_instr  input   7   {is_load, cache_slot, regfile_reg, zero_flag, skip_flag}
// - cache_addr, main_mem_addr, d_cache_addr, d_main_mem_addr  input  18 each  APU addresses/strides
// - queue_full         output  1   count == DEPTH
// - queue_empty        output  1   count == 0
// - queue_count        output  LOG_DEPTH+1  occupancy
// - queue_error        output  1   sticky protocol-violation flag
// - ld_st_valid/ld_st_ready, ram_valid/ram_ready, arith_valid/arith_ready  out/in  1 each  per-unit issue handshake
// - issue_arith 9, issue_ram 3, issue_ld_st 7, issue_cache_addr/issue_main_mem_addr/issue_d_cache_addr/issue_d_main_mem_addr 18
//                      output      shared head-entry payload, valid for whichever *_valid is high
// - stat_high_water (LOG_DEPTH+1), stat_stall_cycles (32)  output  statistics (see CONFIGURATION)
// BEHAVIOUR
// - Storage: circular buffer, wr_ptr/rd_ptr of LOG_DEPTH+1 bits (extra wrap bit); full = MSBs differ & LSBs equal.
// - Reset (reset_n low, async): pointers 0, count 0, queue_empty=1, queue_full=0, all *_valid=0, queue_error=0,
//   issue payload outputs 0, stats 0. Entry memory is not reset.
// - Push accepted iff queue_we & !queue_full & type!=3 & !flush; entry written at posedge, wr_ptr+1 (wraps DEPTH-1 -> 0).
// - Push while full: dropped, queue_error<=1, even if a pop occurs the same cycle (full is sampled pre-edge).
// - Push with type==3: dropped, queue_error<=1 (loops are retired in the control unit and never reach the queue).
// - Latency: accepted push at edge N -> entry visible at head at N+1 if queue was empty; no same-cycle bypass.
// - Dispatch: exactly one of ld_st_valid/ram_valid/arith_valid is high iff !queue_empty, chosen by head type;
//   payload outputs are the head entry, held stable while valid & !ready. Non-empty with no valid high is illegal.
// - Pop when the selected *_valid & matching *_ready at posedge; rd_ptr+1. Readys of non-selected units are ignored.
// - Strict program order: a stalled head blocks all younger entries (no reorder across units).
// - Simultaneous push & pop: count unchanged; legal at any non-full occupancy; when empty, only push takes effect.
// - When empty: payload outputs driven 0.
// - flush: next cycle pointers 0, count 0, all valids 0; overrides push and pop that cycle; queue_error untouched.
// - Reset asserted mid-transfer: entry in flight is discarded; no valid is asserted until after reset release.
// CONFIGURATION
// - QUEUE_STATS_EN defined: stat_high_water = max queue_count since reset (flush does not clear);
//   stat_stall_cycles +1 each cycle head valid & its ready low, saturates at 2^32-1.
// - QUEUE_STATS_EN undefined: both stat ports tied 0, no counter logic; all other behaviour identical.
// TESTING
// - Push 3 entries types 2,1,0 with arith=9'h1A5, cache_addr=18'h00100, all readys 1 -> arith_valid,ram_valid,ld_st_valid
//   on consecutive cycles in that order, payloads match, queue_empty=1 after the third.
// - Hold all readys 0, push DEPTH+1 entries -> queue_full=1 at count 16, 17th dropped, queue_error=1, count stays 16.
// - Push type=3 -> nothing stored, queue_count 0, queue_error=1; flag persists until reset_n low.
// - Head type 1 with ram_ready=0, arith_ready=1, next entry type 2 -> no pop for 5 cycles, ram payload stable;
//   ram_ready=1 -> ram pop then arith pop next cycle (order preserved); with QUEUE_STATS_EN stat_stall_cycles=5.
// - Fill 10, pulse flush together with queue_we -> next cycle count 0, all valids 0, pushed entry not stored.
// - Run wr_ptr across wrap (40 push/pop pairs at steady occupancy 2) -> data order intact, count stays 2, no error;
//   assert reset_n low mid-stream -> outputs at reset values same cycle, asynchronously.

Source files
------------

// File: rtl/instr_dispatch_queue.sv
// instr_dispatch_queue
//   In-order instruction queue between the control unit and the issue ports.
//   The control unit pushes entries (queue_we + payload). The head entry is
//   offered to exactly one issue port (load/store, RAM or arithmetic),
//   chosen by its type, and is popped when that port's ready is high.
//   A stalled head blocks every younger entry, so program order is kept.
//
// Ports
//   clk, reset_n (async, active low), flush (sync clear)
//   queue_we, queue_instr_type, queue_*_instr, *addr      push side
//   queue_full, queue_empty, queue_count, queue_error     status
//   {ld_st,ram,arith}_valid / _ready                      issue handshakes
//   issue_*                                               head payload (0 when empty)
//   stat_high_water, stat_stall_cycles                    statistics
//
// Optional feature macro: QUEUE_STATS_EN
//   When defined, the statistics counters are built. Otherwise both stat
//   ports are tied to 0.

module instr_dispatch_queue #(
  parameter int unsigned LOG_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 queue_we,
  input  logic [1:0]           queue_instr_type,
  input  logic [8:0]           queue_arith_instr,
  input  logic [2:0]           queue_ram_instr,
  input  logic [6:0]           queue_ld_st_instr,
  input  logic [17:0]          cache_addr,
  input  logic [17:0]          main_mem_addr,
  input  logic [17:0]          d_cache_addr,
  input  logic [17:0]          d_main_mem_addr,
  output logic                 queue_full,
  output logic                 queue_empty,
  output logic [LOG_DEPTH:0]   queue_count,
  output logic                 queue_error,
  output logic                 ld_st_valid,
  input  logic                 ld_st_ready,
  output logic                 ram_valid,
  input  logic                 ram_ready,
  output logic                 arith_valid,
  input  logic                 arith_ready,
  output logic [8:0]           issue_arith,
  output logic [2:0]           issue_ram,
  output logic [6:0]           issue_ld_st,
  output logic [17:0]          issue_cache_addr,
  output logic [17:0]          issue_main_mem_addr,
  output logic [17:0]          issue_d_cache_addr,
  output logic [17:0]          issue_d_main_mem_addr,
  output logic [LOG_DEPTH:0]   stat_high_water,
  output logic [31:0]          stat_stall_cycles
);

  localparam int unsigned DEPTH = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] PTR_ONE = {{LOG_DEPTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    TYPE_LD_ST = 2'd0,
    TYPE_RAM   = 2'd1,
    TYPE_ARITH = 2'd2,
    TYPE_LOOP  = 2'd3
  } instr_type_e;

  typedef struct packed {
    instr_type_e  itype;
    logic [8:0]   arith;
    logic [2:0]   ram;
    logic [6:0]   ld_st;
    logic [17:0]  cache_addr;
    logic [17:0]  main_mem_addr;
    logic [17:0]  d_cache_addr;
    logic [17:0]  d_main_mem_addr;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [LOG_DEPTH:0] wr_ptr;
  logic [LOG_DEPTH:0] rd_ptr;
  entry_t             head;
  entry_t             new_entry;
  logic               head_valid;
  logic               sel_ready;
  logic               push_ok;
  logic               pop;

  // Status is derived from the pointers alone, so an asynchronous reset of
  // the pointers immediately forces empty, all valids low and payload zero.
  assign queue_count = wr_ptr - rd_ptr;
  assign queue_empty = (wr_ptr == rd_ptr);
  assign queue_full  = (wr_ptr[LOG_DEPTH] != rd_ptr[LOG_DEPTH]) &&
                       (wr_ptr[LOG_DEPTH-1:0] == rd_ptr[LOG_DEPTH-1:0]);

  assign head = mem[rd_ptr[LOG_DEPTH-1:0]];

  assign new_entry = '{
    itype:           instr_type_e'(queue_instr_type),
    arith:           queue_arith_instr,
    ram:             queue_ram_instr,
    ld_st:           queue_ld_st_instr,
    cache_addr:      cache_addr,
    main_mem_addr:   main_mem_addr,
    d_cache_addr:    d_cache_addr,
    d_main_mem_addr: d_main_mem_addr
  };

  // Full is the pre-edge value: a push while full is dropped even if the
  // head pops in the same cycle.
  assign push_ok = queue_we && !queue_full && !flush &&
                   (instr_type_e'(queue_instr_type) != TYPE_LOOP);

  always_comb begin
    ld_st_valid           = 1'b0;
    ram_valid             = 1'b0;
    arith_valid           = 1'b0;
    sel_ready             = 1'b0;
    issue_arith           = '0;
    issue_ram             = '0;
    issue_ld_st           = '0;
    issue_cache_addr      = '0;
    issue_main_mem_addr   = '0;
    issue_d_cache_addr    = '0;
    issue_d_main_mem_addr = '0;
    if (!queue_empty) begin
      issue_arith           = head.arith;
      issue_ram             = head.ram;
      issue_ld_st           = head.ld_st;
      issue_cache_addr      = head.cache_addr;
      issue_main_mem_addr   = head.main_mem_addr;
      issue_d_cache_addr    = head.d_cache_addr;
      issue_d_main_mem_addr = head.d_main_mem_addr;
      case (head.itype)
        TYPE_LD_ST: begin ld_st_valid = 1'b1; sel_ready = ld_st_ready; end
        TYPE_RAM:   begin ram_valid   = 1'b1; sel_ready = ram_ready;   end
        TYPE_ARITH: begin arith_valid = 1'b1; sel_ready = arith_ready; end
        default:    ;
      endcase
    end
  end

  assign head_valid = ld_st_valid || ram_valid || arith_valid;
  assign pop        = head_valid && sel_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[LOG_DEPTH-1:0]] <= new_entry;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      queue_error <= 1'b0;
    end else if (queue_we && !flush &&
                 (queue_full || instr_type_e'(queue_instr_type) == TYPE_LOOP)) begin
      queue_error <= 1'b1;
    end
  end

`ifdef QUEUE_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_high_water   <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (queue_count > stat_high_water) stat_high_water <= queue_count;
      if (head_valid && !sel_ready && (stat_stall_cycles != '1))
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`else
  assign stat_high_water   = '0;
  assign stat_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_instr_dispatch_queue.sv
module tb_instr_dispatch_queue;

  typedef struct packed {
    logic [1:0]  t;
    logic [8:0]  a;
    logic [2:0]  r;
    logic [6:0]  l;
    logic [17:0] ca;
    logic [17:0] mm;
    logic [17:0] dca;
    logic [17:0] dmm;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        queue_we = 1'b0;
  logic [1:0]  queue_instr_type = '0;
  logic [8:0]  queue_arith_instr = '0;
  logic [2:0]  queue_ram_instr = '0;
  logic [6:0]  queue_ld_st_instr = '0;
  logic [17:0] cache_addr = '0, main_mem_addr = '0, d_cache_addr = '0, d_main_mem_addr = '0;
  logic        queue_full, queue_empty, queue_error;
  logic [4:0]  queue_count;
  logic        ld_st_valid, ram_valid, arith_valid;
  logic        ld_st_ready = 1'b0, ram_ready = 1'b0, arith_ready = 1'b0;
  logic [8:0]  issue_arith;
  logic [2:0]  issue_ram;
  logic [6:0]  issue_ld_st;
  logic [17:0] issue_cache_addr, issue_main_mem_addr, issue_d_cache_addr, issue_d_main_mem_addr;
  logic [4:0]  stat_high_water;
  logic [31:0] stat_stall_cycles;

  int checks = 0;
  int errors = 0;
  ent_t sb[$];

  instr_dispatch_queue #(.LOG_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .queue_we(queue_we),
    .queue_instr_type(queue_instr_type), .queue_arith_instr(queue_arith_instr),
    .queue_ram_instr(queue_ram_instr), .queue_ld_st_instr(queue_ld_st_instr),
    .cache_addr(cache_addr), .main_mem_addr(main_mem_addr),
    .d_cache_addr(d_cache_addr), .d_main_mem_addr(d_main_mem_addr),
    .queue_full(queue_full), .queue_empty(queue_empty), .queue_count(queue_count),
    .queue_error(queue_error),
    .ld_st_valid(ld_st_valid), .ld_st_ready(ld_st_ready),
    .ram_valid(ram_valid), .ram_ready(ram_ready),
    .arith_valid(arith_valid), .arith_ready(arith_ready),
    .issue_arith(issue_arith), .issue_ram(issue_ram), .issue_ld_st(issue_ld_st),
    .issue_cache_addr(issue_cache_addr), .issue_main_mem_addr(issue_main_mem_addr),
    .issue_d_cache_addr(issue_d_cache_addr), .issue_d_main_mem_addr(issue_d_main_mem_addr),
    .stat_high_water(stat_high_water), .stat_stall_cycles(stat_stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic [1:0] t, input logic [8:0] a, input logic [17:0] ca);
    ent_t e;
    e.t = t; e.a = a; e.r = a[2:0] ^ 3'h5; e.l = a[6:0] ^ 7'h2A;
    e.ca = ca; e.mm = ca ^ 18'h3F0F0; e.dca = ca + 18'd4; e.dmm = ~ca;
    return e;
  endfunction

  // Drive one push across one rising edge; record it if the bench expects acceptance.
  task automatic push(input ent_t e, input bit ok);
    queue_we = 1'b1;
    queue_instr_type = e.t; queue_arith_instr = e.a; queue_ram_instr = e.r;
    queue_ld_st_instr = e.l; cache_addr = e.ca; main_mem_addr = e.mm;
    d_cache_addr = e.dca; d_main_mem_addr = e.dmm;
    @(posedge clk); #1;
    queue_we = 1'b0;
    if (ok) sb.push_back(e);
  endtask

  task automatic set_ready(input logic v);
    ld_st_ready = v; ram_ready = v; arith_ready = v;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_drained"}, sb.size(), 0);
    chk({name, "_empty"}, queue_empty, 1);
  endtask

  // Monitor: compares every dispatched head against the scoreboard front.
  always @(negedge clk) begin
    if (reset_n) begin
      int nv;
      logic [1:0] at;
      ent_t act, e;
      nv = int'(ld_st_valid) + int'(ram_valid) + int'(arith_valid);
      chk("valid_onehot", nv, queue_empty ? 0 : 1);
      if ((ld_st_valid && ld_st_ready) || (ram_valid && ram_ready) || (arith_valid && arith_ready)) begin
        at = ld_st_valid ? 2'd0 : (ram_valid ? 2'd1 : 2'd2);
        act = '{t: at, a: issue_arith, r: issue_ram, l: issue_ld_st, ca: issue_cache_addr,
                mm: issue_main_mem_addr, dca: issue_d_cache_addr, dmm: issue_d_main_mem_addr};
        if (sb.size() == 0) begin
          chk("unexpected_dispatch", act, '0);
        end else begin
          e = sb.pop_front();
          chk("dispatch", act, e);
        end
      end
    end
  end

  initial begin
    logic [31:0] s0;
    ent_t er, ea;

    // Reset state
    #2;
    chk("rst_empty", queue_empty, 1);
    chk("rst_full", queue_full, 0);
    chk("rst_count", queue_count, 0);
    chk("rst_valids", {ld_st_valid, ram_valid, arith_valid}, 0);
    chk("rst_error", queue_error, 0);
    chk("rst_payload", {issue_arith, issue_cache_addr}, 0);
    chk("rst_stats", {stat_high_water, stat_stall_cycles}, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Three entries of different types, all ports ready: dispatched in order
    set_ready(1'b1);
    push(mk(2'd2, 9'h1A5, 18'h00100), 1'b1);
    push(mk(2'd1, 9'h0C3, 18'h00100), 1'b1);
    push(mk(2'd0, 9'h011, 18'h00100), 1'b1);
    @(posedge clk); #1;
    chk("seq_empty", queue_empty, 1);
    chk("seq_sb", sb.size(), 0);
    set_ready(1'b0);

    // Fill to DEPTH with ports stalled, then one more push is dropped
    for (int i = 0; i < 16; i++) push(mk(2'(i % 3), 9'(i + 32), 18'(i * 7)), 1'b1);
    chk("fill_full", queue_full, 1);
    chk("fill_count", queue_count, 16);
    chk("fill_err0", queue_error, 0);
    push(mk(2'd2, 9'h1FF, 18'h3FFFF), 1'b0);
    chk("ovf_count", queue_count, 16);
    chk("ovf_error", queue_error, 1);
`ifdef QUEUE_STATS_EN
    chk("high_water", stat_high_water, 16);
`else
    chk("high_water_off", stat_high_water, 0);
`endif
    set_ready(1'b1);
    drain("ovf");
    set_ready(1'b0);
    chk("err_sticky", queue_error, 1);
    reset_n = 1'b0; #1;
    chk("err_cleared", queue_error, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Loop-type push is illegal and never stored
    push(mk(2'd3, 9'h055, 18'h00001), 1'b0);
    chk("loop_count", queue_count, 0);
    chk("loop_empty", queue_empty, 1);
    chk("loop_error", queue_error, 1);
    repeat (3) @(posedge clk);
    #1 chk("loop_err_sticky", queue_error, 1);
    reset_n = 1'b0; #1;
    chk("loop_err_rst", queue_error, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Stalled RAM head blocks a younger ARITH entry
    er = mk(2'd1, 9'h0A6, 18'h01234);
    ea = mk(2'd2, 9'h133, 18'h04321);
    push(er, 1'b1);
    push(ea, 1'b1);
    arith_ready = 1'b1;
    s0 = stat_stall_cycles;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_count", queue_count, 2);
      chk("stall_ramvalid", {ld_st_valid, ram_valid, arith_valid}, 3'b010);
      chk("stall_payload", issue_ram, er.r);
    end
`ifdef QUEUE_STATS_EN
    chk("stall_stat", stat_stall_cycles - s0, 5);
`else
    chk("stall_stat_off", stat_stall_cycles, 0);
`endif
    ram_ready = 1'b1;
    @(posedge clk); #1;
    chk("order_arith_next", {queue_count, arith_valid}, {5'd1, 1'b1});
    @(posedge clk); #1;
    chk("order_empty", queue_empty, 1);
    chk("order_sb", sb.size(), 0);
    set_ready(1'b0);

    // Flush overrides a same-cycle push
    for (int i = 0; i < 10; i++) push(mk(2'(i % 3), 9'(i + 100), 18'(i * 13)), 1'b1);
    chk("pre_flush_count", queue_count, 10);
    flush = 1'b1;
    push(mk(2'd2, 9'h0EE, 18'h0BEEF), 1'b0);
    flush = 1'b0;
    sb.delete();
    chk("flush_count", queue_count, 0);
    chk("flush_valids", {ld_st_valid, ram_valid, arith_valid}, 0);
    chk("flush_err", queue_error, 0);
    @(posedge clk); #1;
    chk("flush_not_stored", queue_empty, 1);

    // Steady occupancy 2 across pointer wrap
    push(mk(2'd0, 9'h001, 18'h10000), 1'b1);
    push(mk(2'd1, 9'h002, 18'h10001), 1'b1);
    set_ready(1'b1);
    for (int i = 0; i < 40; i++) begin
      push(mk(2'(i % 3), 9'(i + 200), 18'(i * 97)), 1'b1);
      chk("wrap_count", queue_count, 2);
    end
    drain("wrap");
    chk("wrap_error", queue_error, 0);

    // Asynchronous reset mid-stream
    set_ready(1'b0);
    for (int i = 0; i < 3; i++) push(mk(2'(i % 3), 9'(i + 400), 18'(i * 5)), 1'b1);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_valids", {ld_st_valid, ram_valid, arith_valid}, 0);
    chk("arst_count", {queue_count, queue_empty, queue_full}, {5'd0, 1'b1, 1'b0});
    chk("arst_payload", {issue_arith, issue_ram, issue_ld_st, issue_cache_addr,
                         issue_main_mem_addr, issue_d_cache_addr, issue_d_main_mem_addr}, 0);
    chk("arst_stats", {stat_high_water, stat_stall_cycles}, 0);
    sb.delete();
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_empty", {queue_empty, ld_st_valid, ram_valid, arith_valid}, 4'b1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
